// File: rtl/cpu_controller.sv
// Instruction-sequencing control unit: fetches from the instruction ROM, decodes, and drives DataPath controls.
// Optional single-step mode is enabled by defining CPU_CTRL_STEP_EN (adds Step input and WAIT state).
module cpu_controller #(
  parameter int unsigned PC_W = 7,
  parameter int unsigned IW   = 16
) (
  input  logic            Clk,
  input  logic            Reset,
`ifdef CPU_CTRL_STEP_EN
  input  logic            Step,
`endif
  input  logic [IW-1:0]   IM_Data,
  output logic [PC_W-1:0] IM_Addr,
  output logic            IM_Rd,
  output logic [7:0]      D_Addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic            RF_W_en,
  output logic [3:0]      RF_W_addr,
  output logic [3:0]      RF_Ra_addr,
  output logic [3:0]      RF_Rb_addr,
  output logic [2:0]      Alu_s0,
  output logic [3:0]      State,
  output logic            Halted
);

  localparam int unsigned OPC_W = 4;
  localparam int unsigned RA_W  = 4;
  localparam int unsigned DA_W  = 8;
  localparam int unsigned ALU_W = 3;

  localparam logic [OPC_W-1:0] OP_NOOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_STORE = 4'h1;
  localparam logic [OPC_W-1:0] OP_LOAD  = 4'h2;
  localparam logic [OPC_W-1:0] OP_ADD   = 4'h3;
  localparam logic [OPC_W-1:0] OP_SUB   = 4'h4;
  localparam logic [OPC_W-1:0] OP_HALT  = 4'h5;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_STORE  = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
`ifdef CPU_CTRL_STEP_EN
    , S_WAIT = 4'd10
`endif
  } state_e;

  // State entered after INIT and after each instruction's final cycle
`ifdef CPU_CTRL_STEP_EN
  localparam state_e S_RESUME = S_WAIT;
`else
  localparam state_e S_RESUME = S_FETCH;
`endif

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [IW-1:0]     ir_q, ir_d;

  logic              im_rd_c;
  logic [DA_W-1:0]   d_addr_c;
  logic              d_wr_c;
  logic              rf_s_c;
  logic              rf_w_en_c;
  logic [RA_W-1:0]   rf_w_addr_c;
  logic [RA_W-1:0]   rf_ra_addr_c;
  logic [RA_W-1:0]   rf_rb_addr_c;
  logic [ALU_W-1:0]  alu_c;
  logic              halted_c;

  // Opcode bits of IR are consumed at DECODE straight from IM_Data
  logic              unused_ir_opcode;
  assign unused_ir_opcode = ^ir_q[IW-1:12];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    im_rd_c      = 1'b0;
    d_addr_c     = '0;
    d_wr_c       = 1'b0;
    rf_s_c       = 1'b0;
    rf_w_en_c    = 1'b0;
    rf_w_addr_c  = '0;
    rf_ra_addr_c = '0;
    rf_rb_addr_c = '0;
    alu_c        = ALU_PASS;
    halted_c     = 1'b0;

    case (state_q)
      S_INIT: begin
        pc_d    = '0;
        ir_d    = '0;
        state_d = S_RESUME;
      end
`ifdef CPU_CTRL_STEP_EN
      S_WAIT: begin
        if (Step) state_d = S_FETCH;
      end
`endif
      S_FETCH: begin
        im_rd_c = 1'b1;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_d = IM_Data;
        case (IM_Data[IW-1 -: OPC_W])
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_NOOP: begin
        state_d = S_RESUME;
      end
      S_STORE: begin
        d_addr_c     = ir_q[7:0];
        rf_ra_addr_c = ir_q[11:8];
        d_wr_c       = 1'b1;
        state_d      = S_RESUME;
      end
      // LOAD_A absorbs the data-memory read latency; LOAD_B commits the write
      S_LOAD_A, S_LOAD_B: begin
        d_addr_c    = ir_q[11:4];
        rf_s_c      = 1'b1;
        rf_w_addr_c = ir_q[3:0];
        rf_w_en_c   = (state_q == S_LOAD_B);
        state_d     = (state_q == S_LOAD_A) ? S_LOAD_B : S_RESUME;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr_c = ir_q[11:8];
        rf_rb_addr_c = ir_q[7:4];
        rf_w_addr_c  = ir_q[3:0];
        alu_c        = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
        rf_w_en_c    = 1'b1;
        state_d      = S_RESUME;
      end
      S_HALT: begin
        halted_c = 1'b1;
        state_d  = S_HALT;
      end
      default: state_d = S_INIT;
    endcase
  end

  // Write strobes are masked by Reset so nothing commits on a reset edge
  assign IM_Addr    = pc_q;
  assign IM_Rd      = im_rd_c & ~Reset;
  assign D_Addr     = d_addr_c;
  assign D_wr       = d_wr_c & ~Reset;
  assign RF_s       = rf_s_c;
  assign RF_W_en    = rf_w_en_c & ~Reset;
  assign RF_W_addr  = rf_w_addr_c;
  assign RF_Ra_addr = rf_ra_addr_c;
  assign RF_Rb_addr = rf_rb_addr_c;
  assign Alu_s0     = alu_c;
  assign State      = state_q;
  assign Halted     = halted_c;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: ROM and DataPath models, directed programs, write-event scoreboard.
module tb_cpu_controller;

  logic        Clk;
  logic        Reset;
  logic [15:0] IM_Data;
  logic [6:0]  IM_Addr;
  logic        IM_Rd;
  logic [7:0]  D_Addr;
  logic        D_wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_Ra_addr;
  logic [3:0]  RF_Rb_addr;
  logic [2:0]  Alu_s0;
  logic [3:0]  State;
  logic        Halted;

  cpu_controller #(.PC_W(7), .IW(16)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
`ifdef CPU_CTRL_STEP_EN
    .Step       (1'b1),
`endif
    .IM_Data    (IM_Data),
    .IM_Addr    (IM_Addr),
    .IM_Rd      (IM_Rd),
    .D_Addr     (D_Addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_en    (RF_W_en),
    .RF_W_addr  (RF_W_addr),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .Alu_s0     (Alu_s0),
    .State      (State),
    .Halted     (Halted)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Instruction ROM (1-cycle read) and DataPath model (RF, data memory, ALU)
  logic [15:0] rom  [128];
  logic [15:0] rf   [16];
  logic [15:0] dmem [256];
  logic [15:0] dmem_q;
  logic [15:0] alu_y;

  always_comb begin
    case (Alu_s0)
      3'd1:    alu_y = rf[RF_Ra_addr] + rf[RF_Rb_addr];
      3'd2:    alu_y = rf[RF_Ra_addr] - rf[RF_Rb_addr];
      default: alu_y = rf[RF_Ra_addr];
    endcase
  end

  always @(posedge Clk) begin
    if (IM_Rd) IM_Data <= rom[IM_Addr];
    dmem_q <= dmem[D_Addr];
    if (Reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
      for (int i = 0; i < 256; i++) dmem[i] <= 16'd0;
      rf[1]   <= 16'd222;
      rf[2]   <= 16'd222;
      dmem[0] <= 16'd123;
    end else begin
      if (D_wr) dmem[D_Addr] <= rf[RF_Ra_addr];
      if (RF_W_en) rf[RF_W_addr] <= RF_s ? dmem_q : alu_y;
    end
  end

  // Scoreboard of expected write events, in program order
  typedef struct {
    bit is_mem;
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  task automatic push_wr(input bit m, input int a, input int d);
    wr_t e;
    e.is_mem = m;
    e.addr   = a;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  always @(negedge Clk) begin
    if (D_wr || RF_W_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: D_wr=%0b RF_W_en=%0b state=%0d, required no write (t=%0t)",
                 D_wr, RF_W_en, State, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_kind_is_mem", longint'(D_wr), longint'(mon_e.is_mem));
        if (D_wr) begin
          chk("mem_wr_addr", longint'(D_Addr), longint'(mon_e.addr));
          chk("mem_wr_data", longint'(rf[RF_Ra_addr]), longint'(mon_e.data));
        end else begin
          chk("rf_wr_addr", longint'(RF_W_addr), longint'(mon_e.addr));
          chk("rf_wr_data", longint'(RF_s ? dmem_q : alu_y), longint'(mon_e.data));
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // State sequence after reset release for the main program
  int exp_st [26] = '{1,2,5,6, 1,2,4, 1,2,5,6, 1,2,7, 1,2,8, 1,2,3, 1,2,7, 1,2,9};

  initial begin
    int  fetch_n;
    bit  found;

    Reset = 1'b1;
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h2005;  // LOAD R5 <- mem[0x00]
    rom[1] = 16'h1209;  // STORE mem[9] <- R2
    rom[2] = 16'h2002;  // LOAD R2 <- mem[0x00]
    rom[3] = 16'h3123;  // ADD R3 = R1 + R2
    rom[4] = 16'h4124;  // SUB R4 = R1 - R2
    rom[5] = 16'hF000;  // undefined opcode, NOOP
    rom[6] = 16'h3556;  // ADD R6 = R5 + R5
    rom[7] = 16'h5000;  // HALT
    rom[8] = 16'h3117;  // must never execute

    push_wr(1'b0, 5, 123);
    push_wr(1'b1, 9, 222);
    push_wr(1'b0, 2, 123);
    push_wr(1'b0, 3, 345);
    push_wr(1'b0, 4, 99);
    push_wr(1'b0, 6, 246);

    tick();
    tick();
    chk("reset_all_outputs_zero",
        longint'({IM_Addr, IM_Rd, D_Addr, D_wr, RF_s, RF_W_en, RF_W_addr,
                  RF_Ra_addr, RF_Rb_addr, Alu_s0, State, Halted}), 0);
    Reset = 1'b0;
    #2;
    chk("init_after_release", longint'(State), 0);

    fetch_n = 0;
    for (int i = 0; i < 26; i++) begin
      tick();
      chk($sformatf("state_cyc%0d", i), longint'(State), longint'(exp_st[i]));
      if (State == 4'd1) begin
        chk($sformatf("fetch_addr_cyc%0d", i), longint'(IM_Addr), longint'(fetch_n));
        chk($sformatf("fetch_rd_cyc%0d", i), longint'(IM_Rd), 1);
        fetch_n++;
      end else if (State == 4'd2) begin
        chk($sformatf("decode_pc_cyc%0d", i), longint'(IM_Addr), longint'(fetch_n));
      end
      case (i)
        2: begin
          chk("loada_daddr", longint'(D_Addr), 0);
          chk("loada_rfs", longint'(RF_s), 1);
          chk("loada_waddr", longint'(RF_W_addr), 5);
          chk("loada_wen", longint'(RF_W_en), 0);
        end
        3: begin
          chk("loadb_wen", longint'(RF_W_en), 1);
          chk("loadb_waddr", longint'(RF_W_addr), 5);
        end
        4: chk("rf5_after_load", longint'(rf[5]), 123);
        6: begin
          chk("store_dwr", longint'(D_wr), 1);
          chk("store_daddr", longint'(D_Addr), 9);
          chk("store_ra", longint'(RF_Ra_addr), 2);
        end
        13: begin
          chk("add_alu", longint'(Alu_s0), 1);
          chk("add_waddr", longint'(RF_W_addr), 3);
          chk("add_ra_rb", longint'({RF_Ra_addr, RF_Rb_addr}), 18);
          chk("add_wen_rfs", longint'({RF_W_en, RF_s}), 2);
        end
        16: begin
          chk("sub_alu", longint'(Alu_s0), 2);
          chk("sub_waddr", longint'(RF_W_addr), 4);
        end
        19: chk("noop_f_outputs",
                longint'({IM_Rd, D_Addr, D_wr, RF_s, RF_W_en, RF_W_addr,
                          RF_Ra_addr, RF_Rb_addr, Alu_s0, Halted}), 0);
        22: chk("rb_reads_r5", longint'(rf[RF_Rb_addr]), 123);
        25: begin
          chk("halted_flag", longint'(Halted), 1);
          chk("halt_pc", longint'(IM_Addr), 8);
        end
        default: ;
      endcase
    end

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("halt_hold_state", longint'(State), 9);
      chk("halt_pc_frozen", longint'(IM_Addr), 8);
    end
    chk("mem9", longint'(dmem[9]), 222);
    chk("rf3", longint'(rf[3]), 345);
    chk("rf4", longint'(rf[4]), 99);
    chk("rf6", longint'(rf[6]), 246);

    // Reset out of HALT
    Reset = 1'b1;
    tick();
    chk("halt_reset_state", longint'(State), 0);
    chk("halt_reset_pc", longint'(IM_Addr), 0);
    chk("halt_reset_halted", longint'(Halted), 0);
    Reset = 1'b0;

    // Reset in the middle of LOAD_A: LOAD_B write must never happen
    tick();
    chk("rerun_fetch_pc", longint'({State, IM_Addr}), longint'({4'd1, 7'd0}));
    tick();
    tick();
    chk("rerun_load_a", longint'(State), 5);
    Reset = 1'b1;
    #1;
    chk("reset_in_loada_wen", longint'(RF_W_en), 0);
    tick();
    chk("reset_in_loada_next", longint'(State), 0);

    // PC wrap: fill ROM with NOOPs, opcode F with nonzero fields at 127
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[127] = 16'hF123;
    tick();
    Reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      tick();
      if (State == 4'd1 && IM_Addr == 7'd127) found = 1'b1;
    end
    chk("wrap_reach_pc127", longint'(found), 1);
    tick();
    chk("wrap_decode_pc0", longint'({State, IM_Addr}), longint'({4'd2, 7'd0}));
    tick();
    chk("wrap_noop_state", longint'(State), 3);
    chk("wrap_noop_outputs",
        longint'({IM_Rd, D_Addr, D_wr, RF_s, RF_W_en, RF_W_addr,
                  RF_Ra_addr, RF_Rb_addr, Alu_s0, Halted}), 0);
    tick();
    chk("wrap_fetch_pc0", longint'({State, IM_Addr}), longint'({4'd1, 7'd0}));

    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Instruction-sequencing control unit for the 16-bit processor.
- Fetches 16-bit instructions from a synchronous instruction ROM through an internal program counter and latches them into an instruction register.
- Decodes each instruction and drives every control input of the `DataPath` block for one execute step: data-memory write, register-file write, write-back mux select, register addresses and ALU select.
- Sits between the instruction ROM and `DataPath` in the top-level processor.

## Interface
Parameters:
- `PC_W`, default 7: program counter and instruction address width.
- `IW`, default 16: instruction width.

Ports:
- `Clk` input, 1: system clock. All state changes on the rising edge.
- `Reset` input, 1: synchronous, active-high reset.
- `IM_Data` input, 16: instruction ROM read data. Valid the cycle after `IM_Rd` is asserted.
- `IM_Addr` output, PC_W: instruction ROM address (equals the PC).
- `IM_Rd` output, 1: instruction ROM read strobe.
- `D_Addr` output, 8: data-memory address to `DataPath`.
- `D_wr` output, 1: data-memory write enable.
- `RF_s` output, 1: write-back select. 1 = data memory, 0 = ALU.
- `RF_W_en` output, 1: register-file write enable.
- `RF_W_addr`, `RF_Ra_addr`, `RF_Rb_addr` outputs, 4 each: register-file write, read-A and read-B addresses.
- `Alu_s0` output, 3: ALU function. 0 = pass/idle, 1 = add (A+B), 2 = subtract (A−B).
- `State` output, 4: current FSM state encoding, for debug and bench visibility.
- `Halted` output, 1: high while in HALT.

## Operation
Instruction format is `IR[15:12]` = opcode.
- NOOP 0000: no operation.
- STORE 0001: `Ra = IR[11:8]`, `D_Addr = IR[7:0]`; writes `RF[Ra]` to memory.
- LOAD 0010: `D_Addr = IR[11:4]`, `Rd = IR[3:0]`; writes memory data to `RF[Rd]`.
- ADD 0011: `Ra = IR[11:8]`, `Rb = IR[7:4]`, `Rd = IR[3:0]`; `RF[Rd] = RF[Ra] + RF[Rb]`.
- SUB 0100: same fields as ADD; `RF[Rd] = RF[Ra] − RF[Rb]`.
- HALT 0101: stop.
- Opcodes 0110–1111 execute as NOOP.

States and encodings:
- INIT (0): PC ← 0, IR ← 0. Next: FETCH.
- FETCH (1): `IM_Rd` = 1, `IM_Addr` = PC. PC ← PC+1 at end of cycle. Next: DECODE.
- DECODE (2): IR ← `IM_Data`. Next state is chosen from `IM_Data[15:12]` directly:
  - NOOP (3) for opcode 0000 and any undefined opcode.
  - STORE (4), LOAD_A (5), ADD (7), SUB (8), HALT (9) for their opcodes.
- NOOP: all enables 0. Next: FETCH.
- STORE: `D_Addr` = IR[7:0], `RF_Ra_addr` = IR[11:8], `D_wr` = 1. Next: FETCH.
- LOAD_A: `D_Addr` = IR[11:4], `RF_s` = 1, `RF_W_addr` = IR[3:0]. Covers the data-memory read latency. Next: LOAD_B (6).
- LOAD_B: same outputs as LOAD_A plus `RF_W_en` = 1. Next: FETCH.
- ADD / SUB:
  - `RF_Ra_addr` = IR[11:8], `RF_Rb_addr` = IR[7:4], `RF_W_addr` = IR[3:0].
  - `RF_s` = 0, `Alu_s0` = 1 (ADD) or 2 (SUB), `RF_W_en` = 1.
  - Next: FETCH.
- HALT: all enables 0, `Halted` = 1. Remains in HALT until `Reset`.

Output rules:
- Outputs are Moore, decoded from state and IR only.
- Any output not listed for a state is 0.
- `D_wr`, `RF_W_en` and `IM_Rd` are gated combinationally by `!Reset`, so no write commits on a reset edge.

Boundary conditions:
- PC wraps from 2^PC_W−1 to 0 with no flag.
- Address fields are copied unchanged; no range checking.
- `Reset` asserted in any state (including mid-LOAD or HALT): next state is INIT and PC/IR clear. A LOAD_A interrupted by reset never produces its LOAD_B write.

## Timing
- Reset values:
  - State = INIT (0), PC = 0, IR = 0.
  - All outputs 0, including `IM_Addr`, `Alu_s0` and `Halted`.
- First FETCH occurs in the second cycle after `Reset` deasserts.
- Instruction latency, cycles: NOOP 3, STORE 3, ADD 3, SUB 3, LOAD 4.
  - Each count is FETCH + DECODE + execute cycle(s).
- Register-file and memory writes commit on the rising edge that ends the execute state (STORE, LOAD_B, ADD, SUB).
- ROM read latency is exactly 1 cycle; no stall or handshake exists.

## Configuration
- `CPU_CTRL_STEP_EN` defined:
  - Adds input `Step` (1 bit).
  - FETCH is entered only on a cycle where `Step` = 1.
  - Otherwise the FSM holds in a WAIT state (10) with all enables 0.
  - After INIT and after every instruction's final cycle, the FSM goes to WAIT instead of FETCH.
  - Each `Step` pulse executes exactly one instruction.
- Not defined:
  - No `Step` port, no WAIT state.
  - Free-running as described above.

## Test plan
- Reset then run: `Reset` high 2 cycles, low. Required: all outputs 0 during reset, INIT for 1 cycle, then FETCH with `IM_Addr` = 0; PC = 1 entering DECODE.
- LOAD 0x2005 (addr 0x00, Rd 5) with memory[0] = 123: LOAD_A then LOAD_B, with `RF_W_en` = 1 only in LOAD_B. Required: RF[5] = 123 after 4 cycles; B reads 123 when `RF_Rb_addr` = 5.
- STORE 0x1209 with RF[2] = 222: single STORE cycle with `D_wr` = 1, `D_Addr` = 9, `RF_Ra_addr` = 2. Required: memory[9] = 222.
- Program: ADD 0x3123, then SUB 0x4124, with RF[1] = 222 and RF[2] = 123. Required:
  - ADD: `Alu_s0` = 1, `RF_W_addr` = 3, RF[3] = 345.
  - SUB: `Alu_s0` = 2, RF[4] = 99.
  - Each instruction takes 3 cycles.
- HALT 0x5000 followed by any instruction: `Halted` = 1, PC frozen, no further writes for 20 cycles. Then `Reset` returns the FSM to INIT with PC = 0.
- Edge cases:
  - Opcode 0xF used as NOOP: 3 cycles, no enables asserted.
  - PC wrap: run from PC = 127 to PC = 0.
  - Reset asserted during LOAD_A: no `RF_W_en`, next state INIT.
